// File: rtl/rf_wb_arbiter_pkg.sv
// Shared sizes and source identifiers for the register-file writeback path.
package rf_wb_arbiter_pkg;
  localparam int REG_W    = 28;
  localparam int AW       = 4;
  localparam int NUM_REGS = 1 << AW;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-register mask: reserved at issue, retired by the register-file write,
// and consulted for WAW blocking at issue and RAW hazards at decode.
module rf_scoreboard #(
  parameter int AW = rf_wb_arbiter_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          iss_valid,
  output logic          iss_ready,
  input  logic [AW-1:0] iss_dest,
  input  logic          iss_simd,
  input  logic          wen,
  input  logic [AW-1:0] wr_dest,
  input  logic          wr_simd,
  input  logic [AW-1:0] rs0,
  input  logic [AW-1:0] rs1,
  input  logic          rd_simd,
  output logic          hazard
);
  import rf_wb_arbiter_pkg::*;

  localparam int NR = 1 << AW;

  logic [NR-1:0] mask;
  logic [NR-1:0] iss_vec;
  logic [NR-1:0] set_vec;
  logic [NR-1:0] clr_vec;
  logic [NR-1:0] hz_vec;
  logic          init_done;

  // A pair covers idx and idx+1, the index width providing the 15 -> 0 wrap.
  function automatic logic [NR-1:0] reg_bits(input logic [AW-1:0] idx, input logic pair);
    logic [AW-1:0] nxt;
    reg_bits = '0;
    nxt = idx + AW'(1);
    reg_bits[idx] = 1'b1;
    if (pair) reg_bits[nxt] = 1'b1;
  endfunction

  assign iss_vec = reg_bits(iss_dest, iss_simd);
  assign clr_vec = wen ? reg_bits(wr_dest, wr_simd) : '0;
  assign hz_vec  = reg_bits(rs0, rd_simd) | reg_bits(rs1, rd_simd);

  // A register in its final write cycle may be re-reserved; the set then wins.
  assign iss_ready = init_done & ~|(mask & ~clr_vec & iss_vec);
  assign set_vec   = (iss_valid && iss_ready) ? iss_vec : '0;
  assign hazard    = |(mask & hz_vec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask      <= '0;
      init_done <= 1'b0;
    end else begin
      mask      <= (mask & ~clr_vec) | set_vec;
      init_done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wen) begin
      illegal_wb: assert ((mask & clr_vec) == clr_vec)
        else $error("illegal_wb: write to non-pending register %0d", wr_dest);
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter between the ALU and the load unit, driving a
// single registered register-file write port and the decode scoreboard.
module rf_wb_arbiter #(
  parameter int REG_W = rf_wb_arbiter_pkg::REG_W,
  parameter int AW    = rf_wb_arbiter_pkg::AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [AW-1:0]      alu_dest,
  input  logic               alu_simd,
  input  logic [2*REG_W-1:0] alu_data,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  logic [AW-1:0]      mem_dest,
  input  logic               mem_simd,
  input  logic [2*REG_W-1:0] mem_data,
  input  logic               iss_valid,
  output logic               iss_ready,
  input  logic [AW-1:0]      iss_dest,
  input  logic               iss_simd,
  input  logic [AW-1:0]      rs0,
  input  logic [AW-1:0]      rs1,
  input  logic               rd_simd,
  output logic               hazard,
  output logic               rf_wen,
  output logic               rf_iswrSIMD,
  output logic [AW-1:0]      rf_dest_sel,
  output logic [2*REG_W-1:0] rf_data_in
);
  import rf_wb_arbiter_pkg::*;

  src_e last_src;
  logic grant_alu;
  logic grant_mem;
  logic xfer;

  // On a tie, the source that did not win last time takes the port.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (rst_n) begin
      if (alu_valid && mem_valid) begin
        grant_alu = (last_src == SRC_MEM);
        grant_mem = (last_src == SRC_ALU);
      end else begin
        grant_alu = alu_valid;
        grant_mem = mem_valid;
      end
    end
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;
  assign xfer      = grant_alu | grant_mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_src    <= SRC_MEM;
      rf_wen      <= 1'b0;
      rf_iswrSIMD <= 1'b0;
      rf_dest_sel <= '0;
      rf_data_in  <= '0;
    end else begin
      rf_wen <= xfer;
      if (xfer) begin
        last_src    <= grant_alu ? SRC_ALU : SRC_MEM;
        rf_iswrSIMD <= grant_alu ? alu_simd : mem_simd;
        rf_dest_sel <= grant_alu ? alu_dest : mem_dest;
        rf_data_in  <= grant_alu ? alu_data : mem_data;
      end
    end
  end

  rf_scoreboard #(.AW(AW)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_ready (iss_ready),
    .iss_dest  (iss_dest),
    .iss_simd  (iss_simd),
    .wen       (rf_wen),
    .wr_dest   (rf_dest_sel),
    .wr_simd   (rf_iswrSIMD),
    .rs0       (rs0),
    .rs1       (rs1),
    .rd_simd   (rd_simd),
    .hazard    (hazard)
  );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios followed by random traffic, all
// checked against a register-level reference model of arbitration and reservations.
module tb_rf_wb_arbiter;
  localparam int RW = rf_wb_arbiter_pkg::REG_W;
  localparam int A  = rf_wb_arbiter_pkg::AW;
  localparam int N  = 1 << A;
  localparam int DW = 2 * RW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, alu_ready, alu_simd;
  logic [A-1:0]  alu_dest;
  logic [DW-1:0] alu_data;
  logic          mem_valid, mem_ready, mem_simd;
  logic [A-1:0]  mem_dest;
  logic [DW-1:0] mem_data;
  logic          iss_valid, iss_ready, iss_simd;
  logic [A-1:0]  iss_dest;
  logic [A-1:0]  rs0, rs1;
  logic          rd_simd, hazard;
  logic          rf_wen, rf_iswrSIMD;
  logic [A-1:0]  rf_dest_sel;
  logic [DW-1:0] rf_data_in;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest),
    .alu_simd(alu_simd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest),
    .mem_simd(mem_simd), .mem_data(mem_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_dest(iss_dest), .iss_simd(iss_simd),
    .rs0(rs0), .rs1(rs1), .rd_simd(rd_simd), .hazard(hazard),
    .rf_wen(rf_wen), .rf_iswrSIMD(rf_iswrSIMD), .rf_dest_sel(rf_dest_sel),
    .rf_data_in(rf_data_in)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: per-register pending flags, reservation table and the
  // single write that the register file sees in the current cycle.
  bit            pend[N];
  bit            rsv[N];
  bit            rsv_simd[N];
  bit            claimed[N];
  bit            alu_turn;
  bit            ready_armed;
  bit            m_wen, m_simd;
  logic [A-1:0]  m_dest;
  logic [DW-1:0] m_data;
  bit            e_alu_rdy, e_mem_rdy, e_iss_rdy, e_haz;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit covers(input int base, input bit pair, input int r);
    return (r == base) || (pair && r == (base + 1) % N);
  endfunction

  function automatic bit clearing(input int r);
    return m_wen && covers(int'(m_dest), m_simd, r);
  endfunction

  function automatic logic [N-1:0] pend_vec();
    logic [N-1:0] v;
    for (int r = 0; r < N; r++) v[r] = pend[r];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < N; r++) begin
      pend[r] = 0; rsv[r] = 0; rsv_simd[r] = 0; claimed[r] = 0;
    end
    alu_turn = 1; ready_armed = 0;
    m_wen = 0; m_simd = 0; m_dest = '0; m_data = '0;
  endtask

  task automatic expect_now();
    e_alu_rdy = rst_n && alu_valid && (!mem_valid || alu_turn);
    e_mem_rdy = rst_n && mem_valid && (!alu_valid || !alu_turn);
    e_iss_rdy = ready_armed;
    e_haz = 0;
    for (int r = 0; r < N; r++) begin
      if (covers(int'(iss_dest), iss_simd, r) && pend[r] && !clearing(r)) e_iss_rdy = 0;
      if (pend[r] && (covers(int'(rs0), rd_simd, r) || covers(int'(rs1), rd_simd, r))) e_haz = 1;
    end
  endtask

  task automatic model_update();
    bit iss_acc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    iss_acc = iss_valid && e_iss_rdy;
    if (m_wen) begin
      for (int r = 0; r < N; r++) if (clearing(r)) pend[r] = 0;
      rsv[m_dest] = 0;
      claimed[m_dest] = 0;
    end
    if (iss_acc) begin
      for (int r = 0; r < N; r++) if (covers(int'(iss_dest), iss_simd, r)) pend[r] = 1;
      rsv[iss_dest] = 1;
      rsv_simd[iss_dest] = iss_simd;
    end
    m_wen = e_alu_rdy || e_mem_rdy;
    if (e_alu_rdy) begin
      m_dest = alu_dest; m_simd = alu_simd; m_data = alu_data;
      alu_turn = 0; claimed[alu_dest] = 1;
    end else if (e_mem_rdy) begin
      m_dest = mem_dest; m_simd = mem_simd; m_data = mem_data;
      alu_turn = 1; claimed[mem_dest] = 1;
    end
    ready_armed = 1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    expect_now();
    chk("alu_ready",   64'(alu_ready),   64'(e_alu_rdy));
    chk("mem_ready",   64'(mem_ready),   64'(e_mem_rdy));
    chk("iss_ready",   64'(iss_ready),   64'(e_iss_rdy));
    chk("hazard",      64'(hazard),      64'(e_haz));
    chk("rf_wen",      64'(rf_wen),      64'(m_wen));
    chk("rf_iswrSIMD", 64'(rf_iswrSIMD), 64'(m_simd));
    chk("rf_dest_sel", 64'(rf_dest_sel), 64'(m_dest));
    chk("rf_data_in",  64'(rf_data_in),  64'(m_data));
    chk("mask",        64'(dut.u_sb.mask), 64'(pend_vec()));
  endtask

  task automatic at_pos();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    at_neg();
    at_pos();
  endtask

  task automatic drive_idle();
    alu_valid = 0; alu_dest = '0; alu_simd = 0; alu_data = DW'({$urandom(), $urandom()});
    mem_valid = 0; mem_dest = '0; mem_simd = 0; mem_data = DW'({$urandom(), $urandom()});
    iss_valid = 0; iss_dest = '0; iss_simd = 0;
    rs0 = 4'd10; rs1 = 4'd11; rd_simd = 0;
  endtask

  task automatic issue(input logic [A-1:0] d, input bit s);
    drive_idle();
    iss_valid = 1; iss_dest = d; iss_simd = s;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_alu_ready"}, 64'(alu_ready), 64'd0);
    chk({tag, "_mem_ready"}, 64'(mem_ready), 64'd0);
    chk({tag, "_iss_ready"}, 64'(iss_ready), 64'd0);
    chk({tag, "_hazard"},    64'(hazard),    64'd0);
    chk({tag, "_rf_wen"},    64'(rf_wen),    64'd0);
    chk({tag, "_simd"},      64'(rf_iswrSIMD), 64'd0);
    chk({tag, "_dest"},      64'(rf_dest_sel), 64'd0);
    chk({tag, "_data"},      64'(rf_data_in),  64'd0);
    chk({tag, "_mask"},      64'(dut.u_sb.mask), 64'd0);
  endtask

  initial begin
    int q[$];
    int k;
    logic [A-1:0] exp_dest [4];
    exp_dest[0] = 4'd1; exp_dest[1] = 4'd2; exp_dest[2] = 4'd3; exp_dest[3] = 4'd4;

    // Reset with every request asserted
    rst_n = 1;
    drive_idle();
    alu_valid = 1; mem_valid = 1; iss_valid = 1; rs0 = 4'd0;
    model_reset();
    #1 rst_n = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk_reset_outputs("por");
      at_pos();
    end
    rst_n = 1;
    drive_idle();
    at_neg();
    chk("iss_ready_before_edge", 64'(iss_ready), 64'd0);
    at_pos();
    at_neg();
    chk("iss_ready_after_edge", 64'(iss_ready), 64'd1);
    at_pos();

    // Simultaneous ALU/MEM requests alternate, no bubbles on rf_wen
    for (int r = 1; r <= 4; r++) begin
      issue(4'(r), 0);
      cycle();
    end
    for (int i = 0; i < 5; i++) begin
      drive_idle();
      if (i < 4) begin
        alu_valid = 1; mem_valid = 1;
        alu_dest = (i < 2) ? 4'(2 * (i / 2) + 1) : ((i == 2) ? 4'd3 : 4'd4);
        mem_dest = (i < 2) ? 4'd2 : 4'd4;
      end
      at_neg();
      if (i < 4) begin
        chk("rr_alu_ready", 64'(alu_ready), 64'((i % 2) == 0));
        chk("rr_mem_ready", 64'(mem_ready), 64'((i % 2) == 1));
      end
      if (i > 0) begin
        chk("rr_rf_wen", 64'(rf_wen), 64'd1);
        chk("rr_rf_dest", 64'(rf_dest_sel), 64'(exp_dest[i-1]));
      end
      at_pos();
    end

    // Scalar ALU write of register 7
    issue(4'd7, 0);
    cycle();
    drive_idle();
    alu_valid = 1; alu_dest = 4'd7; alu_data = {28'hABCDEF1, 28'h1234567};
    cycle();
    drive_idle();
    at_neg();
    chk("scalar_wen",  64'(rf_wen), 64'd1);
    chk("scalar_simd", 64'(rf_iswrSIMD), 64'd0);
    chk("scalar_dest", 64'(rf_dest_sel), 64'd7);
    chk("scalar_upper", 64'(rf_data_in[2*RW-1:RW]), 64'h0ABCDEF1);
    at_pos();

    // Pair reservation wrapping 15 -> 0
    issue(4'd15, 1);
    cycle();
    drive_idle();
    rs0 = 4'd0; rs1 = 4'd10;
    mem_valid = 1; mem_dest = 4'd15; mem_simd = 1;
    at_neg();
    chk("wrap_bit15", 64'(dut.u_sb.mask[15]), 64'd1);
    chk("wrap_bit0",  64'(dut.u_sb.mask[0]),  64'd1);
    chk("wrap_hazard_rs0", 64'(hazard), 64'd1);
    at_pos();
    drive_idle();
    rs0 = 4'd0; rs1 = 4'd10;
    at_neg();
    chk("wrap_wen", 64'(rf_wen), 64'd1);
    chk("wrap_hazard_in_wen", 64'(hazard), 64'd1);
    at_pos();
    at_neg();
    chk("wrap_mask_clear", 64'({dut.u_sb.mask[15], dut.u_sb.mask[0]}), 64'd0);
    chk("wrap_hazard_clear", 64'(hazard), 64'd0);
    at_pos();

    // WAW blocking on register 3
    issue(4'd3, 0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      issue(4'd3, 0);
      if (i == 2) begin alu_valid = 1; alu_dest = 4'd3; end
      at_neg();
      chk("waw_blocked", 64'(iss_ready), 64'd0);
      at_pos();
    end
    drive_idle();
    iss_dest = 4'd3;
    cycle();
    issue(4'd3, 0);
    at_neg();
    chk("waw_released", 64'(iss_ready), 64'd1);
    at_pos();
    drive_idle();
    alu_valid = 1; alu_dest = 4'd3;
    cycle();
    drive_idle();
    cycle();

    // Same-cycle clear and set of register 5
    issue(4'd5, 0);
    cycle();
    drive_idle();
    alu_valid = 1; alu_dest = 4'd5;
    cycle();
    issue(4'd5, 0);
    at_neg();
    chk("r5_wen", 64'(rf_wen), 64'd1);
    chk("r5_reissue_ready", 64'(iss_ready), 64'd1);
    at_pos();
    drive_idle();
    at_neg();
    chk("r5_still_pending", 64'(dut.u_sb.mask[5]), 64'd1);
    at_pos();
    drive_idle();
    alu_valid = 1; alu_dest = 4'd5;
    cycle();
    drive_idle();
    cycle();

    // Reset during the cycle after an ALU grant
    issue(4'd9, 0);
    cycle();
    drive_idle();
    alu_valid = 1; alu_dest = 4'd9;
    cycle();
    rst_n = 0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      at_neg();
      chk_reset_outputs("midrst");
      at_pos();
    end
    rst_n = 1;
    drive_idle();
    at_neg();
    chk("midrst_iss_before_edge", 64'(iss_ready), 64'd0);
    at_pos();
    at_neg();
    chk("midrst_iss_after_edge", 64'(iss_ready), 64'd1);
    at_pos();

    // Random traffic; writebacks only target reserved, unclaimed registers
    for (int c = 0; c < 600; c++) begin
      drive_idle();
      q = {};
      for (int r = 0; r < N; r++) if (rsv[r] && !claimed[r]) q.push_back(r);
      alu_dest = 4'($urandom_range(0, N - 1));
      mem_dest = 4'($urandom_range(0, N - 1));
      if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
        k = $urandom_range(0, q.size() - 1);
        alu_valid = 1; alu_dest = 4'(q[k]); alu_simd = rsv_simd[q[k]];
        q.delete(k);
      end
      if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
        k = $urandom_range(0, q.size() - 1);
        mem_valid = 1; mem_dest = 4'(q[k]); mem_simd = rsv_simd[q[k]];
      end
      iss_valid = ($urandom_range(0, 2) != 0);
      iss_dest  = 4'($urandom_range(0, N - 1));
      iss_simd  = 1'($urandom_range(0, 1));
      rs0 = 4'($urandom_range(0, N - 1));
      rs1 = 4'($urandom_range(0, N - 1));
      rd_simd = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
